lsu_sram_bridge: RTL and testbench
==================================

// Module: lsu_sram_bridge
// PURPOSE
//  Load/store bridge between the core's memory request and a synchronous single-port 32-bit SRAM.
//  Takes byte/halfword/word loads and stores with the same size code the core already drives.
//  Drives SRAM byte enables and lane-aligned write data; sign/zero-extends load data.
//  Flags misaligned or out-of-range accesses.
//  Multi-cycle request/ready handshake; replaces the core's combinational memory model.
// PARAMETERS
//  AW           11  SRAM word-address width; byte space is 4*2**AW bytes (8 KiB default)
//  WAIT_STATES  0   extra wait cycles inserted after the SRAM access cycle (0..15)
//  RD_LAT       1   SRAM read latency in cycles from sram_cs to valid sram_rdata (1..3)
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset, asynchronous, active-high
//  req          in   1     core request; held until ready
//  we           in   1     1=store, 0=load; sampled with req
//  addr         in   32    byte address
//  wdata        in   32    store data, right-justified
//  size         in   4     {b,bu,h,hu}; all zero = word; priority b>bu>h>hu if several set
//  rdata        out  32    extended load result; held until next completed load
//  ready        out  1     one-cycle completion pulse
//  fault        out  1     valid with ready: access rejected, no SRAM cycle issued
//  sram_cs      out  1     SRAM access strobe
//  sram_we      out  1     SRAM write (valid with sram_cs)
//  sram_be      out  4     byte enables (valid with sram_cs)
//  sram_addr    out  AW    word address = addr[AW+1:2]
//  sram_wdata   out  32    lane-shifted store data
//  sram_rdata   in   32    SRAM read data; stable from RD_LAT cycles after sram_cs until next sram_cs
// BEHAVIOUR
//  Reset (async): state=IDLE; rdata=0; all other outputs 0.
//  FSM states and transitions:
//   IDLE: req sampled high at edge E0; all inputs latched at E0.
//         Fault check (below): fail -> DONE with fault=1; pass -> ACCESS.
//   ACCESS: exactly one cycle, sram_cs=1, be/wdata/addr from latched values.
//         Next state: WAIT if N=WAIT_STATES+(load?RD_LAT:0) > 0, else DONE.
//   WAIT: N cycles, down-counter; load captures sram_rdata on the edge leaving WAIT.
//   DONE: one cycle, ready=1 (fault per check), then IDLE.
//  Timing: ready rises at edge E0+1+N for accesses, E0 for faults.
//  Fault check:
//   - halfword with addr[0]!=0 -> fault
//   - word with addr[1:0]!=0 -> fault
//   - addr[31:AW+2]!=0 -> fault
//   - on fault: rdata unchanged, SRAM untouched
//  Lanes (lane = addr[1:0]):
//   - byte:     be=1<<lane; sram_wdata = {4{wdata[7:0]}}
//   - halfword: be=0011 or 1100; sram_wdata = {2{wdata[15:0]}}
//   - word:     be=1111; sram_wdata = wdata
//   - loads drive be=1111, sram_we=0
//   - load result: selected lane shifted to bit 0; b/h sign-extend, bu/hu zero-extend
//  Handshake:
//   - req ignored outside IDLE; req dropping mid-access does not abort, ready still pulses
//   - req still high in the IDLE cycle after DONE starts a new transaction (back-to-back allowed)
//  Stores never update rdata.
//  Reset mid-operation: immediate return to IDLE, sram_cs/ready drop same cycle.
//  A store already sampled by the SRAM is not rolled back.
// TESTING (AW=11, WAIT_STATES=0, RD_LAT=1 unless stated)
//  1. sw 0xDEADBEEF @0x10 -> be=1111, ready at E0+1.
//     lw @0x10 -> ready at E0+2, rdata=0xDEADBEEF.
//  2. sb 0x80 @0x13 -> be=1000, sram_wdata[31:24]=0x80.
//     lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> 0x80ADBEEF.
//  3. lh @0x12 -> 0xFFFF80AD; lhu @0x12 -> 0x000080AD.
//     lh @0x11 -> ready at E0, fault=1, no sram_cs, rdata unchanged.
//  4. lw @0x2000 (out of range) and sw @0x0E (misaligned) -> fault=1, no SRAM write.
//  5. WAIT_STATES=3, RD_LAT=2 lw -> sram_cs for exactly 1 cycle, ready at E0+6.
//     Back-to-back held req -> second access begins the cycle after ready.
//  6. rst pulsed during WAIT of a load -> ready never pulses, rdata=0, state IDLE.
//     Next lw completes normally.

Source files
------------

// File: rtl/lsu_sram_bridge.sv
// Load/store bridge from the core memory request to a synchronous single-port 32-bit SRAM.
// Handles byte/halfword/word lanes, load extension, alignment/range faults and wait states.
module lsu_sram_bridge #(
   parameter int AW          = 11,
   parameter int WAIT_STATES = 0,
   parameter int RD_LAT      = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    size,
   output logic [31:0]   rdata,
   output logic          ready,
   output logic          fault,
   output logic          sram_cs,
   output logic          sram_we,
   output logic [3:0]    sram_be,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] W_BYTE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_WORD = 2'd2;

   localparam logic [4:0] N_STORE = 5'(WAIT_STATES);
   localparam logic [4:0] N_LOAD  = 5'(WAIT_STATES + RD_LAT);

   state_t        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          we_q;
   logic          sgn_q;
   logic          fault_q;
   logic [1:0]    width_q;
   logic [1:0]    lane_q;
   logic [3:0]    be_q;
   logic [AW-1:0] waddr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;

   logic [1:0]    req_width;
   logic          req_sgn;
   logic          req_fault;
   logic [3:0]    req_be;
   logic [31:0]   req_wdata;
   logic [4:0]    n_sel;

   // Shift the addressed lane down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  width,
                                               input logic        sgn);
      logic [31:0] sh;
      sh = raw >> {lane, 3'b000};
      case (width)
         W_BYTE:  return {{24{sgn & sh[7]}}, sh[7:0]};
         W_HALF:  return {{16{sgn & sh[15]}}, sh[15:0]};
         default: return raw;
      endcase
   endfunction

   always_comb begin
      req_width = W_WORD;
      req_sgn   = 1'b0;
      if (size[3]) begin
         req_width = W_BYTE;
         req_sgn   = 1'b1;
      end else if (size[2]) begin
         req_width = W_BYTE;
      end else if (size[1]) begin
         req_width = W_HALF;
         req_sgn   = 1'b1;
      end else if (size[0]) begin
         req_width = W_HALF;
      end

      req_fault = |addr[31:AW+2];
      case (req_width)
         W_HALF:  req_fault = req_fault | addr[0];
         W_WORD:  req_fault = req_fault | (|addr[1:0]);
         default: req_fault = req_fault;
      endcase

      // Loads always read the full word; lane selection happens on capture.
      req_be    = 4'b1111;
      req_wdata = wdata;
      if (we) begin
         case (req_width)
            W_BYTE: begin
               req_be    = 4'b0001 << addr[1:0];
               req_wdata = {4{wdata[7:0]}};
            end
            W_HALF: begin
               req_be    = addr[1] ? 4'b1100 : 4'b0011;
               req_wdata = {2{wdata[15:0]}};
            end
            default: begin
               req_be    = 4'b1111;
               req_wdata = wdata;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_sel   = we_q ? N_STORE : N_LOAD;
      case (state_q)
         S_IDLE: begin
            if (req) state_d = req_fault ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            if (n_sel != 5'd0) begin
               state_d = S_WAIT;
               cnt_d   = n_sel - 5'd1;
            end else begin
               state_d = S_DONE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 5'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 5'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         fault_q <= 1'b0;
         width_q <= W_WORD;
         lane_q  <= 2'd0;
         be_q    <= 4'd0;
         waddr_q <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && req) begin
            we_q    <= we;
            sgn_q   <= req_sgn;
            fault_q <= req_fault;
            width_q <= req_width;
            lane_q  <= addr[1:0];
            be_q    <= req_be;
            waddr_q <= addr[AW+1:2];
            wdata_q <= req_wdata;
         end
         // The final WAIT edge is the only point where load data is guaranteed valid.
         if (state_q == S_WAIT && cnt_q == 5'd0 && !we_q)
            rdata_q <= load_extend(sram_rdata, lane_q, width_q, sgn_q);
      end
   end

   assign sram_cs    = (state_q == S_ACCESS);
   assign sram_we    = sram_cs & we_q;
   assign sram_be    = sram_cs ? be_q : 4'd0;
   assign sram_addr  = waddr_q;
   assign sram_wdata = wdata_q;
   assign ready      = (state_q == S_DONE);
   assign fault      = ready & fault_q;
   assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Randomized bench for lsu_sram_bridge: two instances (fast and slow timing) with SRAM models
// and a byte-addressed reference memory.
module tb_lsu_sram_bridge;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          req        [2];
   logic          we_s;
   logic [31:0]   addr_s, wdata_s;
   logic [3:0]    size_s;
   logic [31:0]   rdata      [2];
   logic          ready      [2];
   logic          fault      [2];
   logic          cs         [2];
   logic          swe        [2];
   logic [3:0]    be         [2];
   logic [AW-1:0] saddr      [2];
   logic [31:0]   swd        [2];
   logic [31:0]   srd        [2];

   lsu_sram_bridge #(.AW(AW), .WAIT_STATES(0), .RD_LAT(1)) dut0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we_s), .addr(addr_s), .wdata(wdata_s),
      .size(size_s), .rdata(rdata[0]), .ready(ready[0]), .fault(fault[0]),
      .sram_cs(cs[0]), .sram_we(swe[0]), .sram_be(be[0]), .sram_addr(saddr[0]),
      .sram_wdata(swd[0]), .sram_rdata(srd[0]));

   lsu_sram_bridge #(.AW(AW), .WAIT_STATES(3), .RD_LAT(2)) dut1 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we_s), .addr(addr_s), .wdata(wdata_s),
      .size(size_s), .rdata(rdata[1]), .ready(ready[1]), .fault(fault[1]),
      .sram_cs(cs[1]), .sram_we(swe[1]), .sram_be(be[1]), .sram_addr(saddr[1]),
      .sram_wdata(swd[1]), .sram_rdata(srd[1]));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, expv);
      end
   endtask

   function automatic int rl(input int i);
      return (i == 0) ? 1 : 2;
   endfunction
   function automatic int ws(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   // SRAM models: write on cs edge, read data appears RD_LAT cycles after cs (garbage before).
   logic [31:0]   smem [2][2048];
   logic [31:0]   pend [2];
   int            pcnt [2];
   int            cs_cnt [2];
   logic [3:0]    last_be [2];
   logic [31:0]   last_wd [2];
   logic [AW-1:0] last_ad [2];
   logic          last_we [2];
   bit            smem_init = 1'b0;

   always @(posedge clk) begin
      if (!smem_init) begin
         for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2048; j++) smem[i][j] = 32'd0;
            cs_cnt[i] = 0;
         end
         smem_init = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            pcnt[i] <= 0;
            srd[i]  <= 32'd0;
         end else if (cs[i]) begin
            cs_cnt[i]  = cs_cnt[i] + 1;
            last_be[i] = be[i];
            last_wd[i] = swd[i];
            last_ad[i] = saddr[i];
            last_we[i] = swe[i];
            if (swe[i]) begin
               for (int b = 0; b < 4; b++)
                  if (be[i][b]) smem[i][saddr[i]][8*b +: 8] <= swd[i][8*b +: 8];
            end else begin
               pend[i] <= smem[i][saddr[i]];
               if (rl(i) == 1) begin
                  srd[i]  <= smem[i][saddr[i]];
                  pcnt[i] <= 0;
               end else begin
                  srd[i]  <= $urandom;
                  pcnt[i] <= rl(i) - 1;
               end
            end
         end else if (pcnt[i] != 0) begin
            pcnt[i] <= pcnt[i] - 1;
            if (pcnt[i] == 1) srd[i] <= pend[i];
         end
      end
   end

   // Reference: flat byte memory per instance plus last completed load value.
   logic [7:0]  rmem [2][8192];
   logic [31:0] exp_rd [2];

   task automatic xact(input int inst, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sz);
      int          nb, exp_lat, lat, cs0;
      bit          sg, flt;
      logic        gf;
      logic [31:0] val, ewd;
      logic [3:0]  ebe;
      if (sz[3])      begin nb = 1; sg = 1'b1; end
      else if (sz[2]) begin nb = 1; sg = 1'b0; end
      else if (sz[1]) begin nb = 2; sg = 1'b1; end
      else if (sz[0]) begin nb = 2; sg = 1'b0; end
      else            begin nb = 4; sg = 1'b0; end
      flt     = (a >= 32'd8192) || ((a % 32'(nb)) != 32'd0);
      exp_lat = flt ? 0 : 1 + ws(inst) + (w ? 0 : rl(inst));
      ebe     = w ? 4'(((1 << nb) - 1) << a[1:0]) : 4'hF;
      ewd     = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
      if (!flt) begin
         if (w) begin
            for (int i = 0; i < nb; i++) rmem[inst][int'(a) + i] = wd[8*i +: 8];
         end else begin
            val = 32'd0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = rmem[inst][int'(a) + i];
            if (nb == 1)      exp_rd[inst] = sg ? {{24{val[7]}}, val[7:0]} : {24'd0, val[7:0]};
            else if (nb == 2) exp_rd[inst] = sg ? {{16{val[15]}}, val[15:0]} : {16'd0, val[15:0]};
            else              exp_rd[inst] = val;
         end
      end
      @(posedge clk); #1;
      we_s = w; addr_s = a; wdata_s = wd; size_s = sz;
      req[inst] = 1'b1;
      cs0 = cs_cnt[inst];
      lat = -1;
      gf  = 1'b0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (ready[inst]) begin
            lat = k;
            gf  = fault[inst];
         end
      end
      req[inst] = 1'b0;
      chk("latency", lat, exp_lat);
      chk("fault", gf, flt);
      chk("cs_count", cs_cnt[inst] - cs0, flt ? 0 : 1);
      chk("rdata", rdata[inst], exp_rd[inst]);
      if (!flt) begin
         chk("sram_be", last_be[inst], ebe);
         chk("sram_we", last_we[inst], w);
         chk("sram_addr", last_ad[inst], a[12:2]);
         if (w) chk("sram_wdata", last_wd[inst], ewd);
      end
      @(posedge clk); #1;
      chk("ready_pulse", ready[inst], 0);
   endtask

   initial begin
      int          inst, r, k1, k2, seen;
      bit          w;
      logic [31:0] a, wd;
      logic [3:0]  sz;

      req[0] = 1'b0; req[1] = 1'b0;
      we_s = 1'b0; addr_s = 32'd0; wdata_s = 32'd0; size_s = 4'd0;
      for (int i = 0; i < 2; i++) begin
         exp_rd[i] = 32'd0;
         for (int j = 0; j < 8192; j++) rmem[i][j] = 8'd0;
      end
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_rdata0", rdata[0], 0);
      chk("rst_ready0", ready[0], 0);
      chk("rst_fault0", fault[0], 0);
      chk("rst_cs0", cs[0], 0);
      chk("rst_be0", be[0], 0);
      chk("rst_wdata0", swd[0], 0);
      chk("rst_addr0", saddr[0], 0);
      chk("rst_rdata1", rdata[1], 0);
      chk("rst_cs1", cs[1], 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0000);
      xact(0, 1'b0, 32'h10, 32'd0, 4'b0000);
      chk("t1_lw", rdata[0], 32'hDEADBEEF);
      xact(0, 1'b1, 32'h13, 32'h00000080, 4'b1000);
      chk("t2_sb_wdata_top", last_wd[0][31:24], 32'h80);
      xact(0, 1'b0, 32'h13, 32'd0, 4'b1000);
      chk("t2_lb", rdata[0], 32'hFFFFFF80);
      xact(0, 1'b0, 32'h13, 32'd0, 4'b0100);
      chk("t2_lbu", rdata[0], 32'h00000080);
      xact(0, 1'b0, 32'h10, 32'd0, 4'b0000);
      chk("t2_lw", rdata[0], 32'h80ADBEEF);
      xact(0, 1'b0, 32'h12, 32'd0, 4'b0010);
      chk("t3_lh", rdata[0], 32'hFFFF80AD);
      xact(0, 1'b0, 32'h12, 32'd0, 4'b0001);
      chk("t3_lhu", rdata[0], 32'h000080AD);
      xact(0, 1'b0, 32'h11, 32'd0, 4'b0010);
      chk("t3_fault_keep", rdata[0], 32'h000080AD);
      xact(0, 1'b0, 32'h2000, 32'd0, 4'b0000);
      xact(0, 1'b1, 32'h0E, 32'h12345678, 4'b0000);
      xact(0, 1'b0, 32'h0C, 32'd0, 4'b0000);
      chk("t4_no_write", rdata[0], 32'h00000000);

      xact(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'b0000);
      xact(1, 1'b0, 32'h20, 32'd0, 4'b0000);
      chk("t5_lw", rdata[1], 32'hCAFEF00D);

      // Back-to-back: req held through two completions.
      @(posedge clk); #1;
      we_s = 1'b0; addr_s = 32'h20; size_s = 4'b0000; req[1] = 1'b1;
      r = cs_cnt[1]; k1 = -1; k2 = -1;
      for (int k = 0; k < 60 && k2 < 0; k++) begin
         @(posedge clk); #1;
         if (ready[1]) begin
            if (k1 < 0) k1 = k;
            else        k2 = k;
         end
         if (k1 >= 0 && k == k1 + 2) chk("b2b_cs", cs[1], 1);
      end
      req[1] = 1'b0;
      chk("b2b_lat1", k1, 6);
      chk("b2b_gap", k2 - k1, 8);
      chk("b2b_cs_count", cs_cnt[1] - r, 2);
      chk("b2b_rdata", rdata[1], 32'hCAFEF00D);
      @(posedge clk); #1;

      // Reset while a slow load sits in its wait cycles.
      @(posedge clk); #1;
      we_s = 1'b0; addr_s = 32'h20; size_s = 4'b0000; req[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      req[1] = 1'b0;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      #1;
      chk("rst_mid_ready", ready[1], 0);
      chk("rst_mid_cs", cs[1], 0);
      chk("rst_mid_rdata1", rdata[1], 0);
      chk("rst_mid_rdata0", rdata[0], 0);
      @(posedge clk); #1 rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ready[1] || cs[1]) seen++;
      end
      chk("rst_quiet", seen, 0);
      xact(1, 1'b0, 32'h20, 32'd0, 4'b0000);
      chk("rst_after_lw", rdata[1], 32'hCAFEF00D);

      repeat (160) begin
         inst = int'($urandom_range(0, 1));
         w    = 1'($urandom_range(0, 1));
         r    = int'($urandom_range(0, 15));
         a    = 32'($urandom_range(0, 63));
         if (r == 0)      a = $urandom;
         else if (r == 1) a = 32'h2000 + 32'($urandom_range(0, 7));
         else if (r == 2) a = 32'd8188 + 32'($urandom_range(0, 3));
         sz = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         wd = $urandom;
         xact(inst, w, a, wd, sz);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
